// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM encoding and legality check shared by the ALU and its decoder
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: is_legal_op = 1'b1;
            default:                                    is_legal_op = 1'b0;
        endcase
    endfunction

    // SUB and SLT both run A + ~B + 1 through the slice adder
    function automatic logic uses_borrow(input logic [3:0] code);
        uses_borrow = (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// rtl/serial_alu_if.sv - start/busy/done request and result bundle between ALU control and serial ALU
interface serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [3:0]       Alucontrol;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Illegal;

    modport master (
        output Start, Alucontrol, A, B,
        input  Busy, Done, Result, Zero, Illegal
    );

    modport slave (
        input  Start, Alucontrol, A, B,
        output Busy, Done, Result, Zero, Illegal
    );
endinterface

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - combinational SLICE-bit logic/adder unit with carry chain and sign taps for SLT
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic [SLICE-1:0] y,
    output logic             cout,
    output logic             a_msb,
    output logic             b_msb,
    output logic             s_msb
);
    logic [SLICE-1:0] bx;
    logic [SLICE:0]   sum;

    always_comb begin
        bx  = uses_borrow(op) ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {{SLICE{1'b0}}, cin};
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = sum[SLICE-1:0];
        endcase
    end

    assign cout  = sum[SLICE];
    assign a_msb = a[SLICE-1];
    assign b_msb = b[SLICE-1];
    assign s_msb = sum[SLICE-1];

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - slice-serial ALU, LSB slice first, one slice per cycle with start/busy/done handshake
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic         clk,
    input  logic         rst,
    serial_alu_if.slave  bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, acc, result;
    logic [3:0]       op;
    logic [CW-1:0]    count;
    logic             carry;
    logic             illegal_pend;

    logic [SLICE-1:0] y;
    logic             cout, a_msb, b_msb, s_msb;
    logic [WIDTH-1:0] acc_nxt;
    logic             slt_bit;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a     (op_a[SLICE-1:0]),
        .b     (op_b[SLICE-1:0]),
        .cin   (carry),
        .op    (op),
        .y     (y),
        .cout  (cout),
        .a_msb (a_msb),
        .b_msb (b_msb),
        .s_msb (s_msb)
    );

    assign acc_nxt = {y, acc[WIDTH-1:SLICE]};
    // signed less-than from the final slice: N xor V
    assign slt_bit = s_msb ^ ((a_msb != b_msb) && (s_msb != a_msb));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = is_legal_op(bus.Alucontrol) ? RUN : DONE;
            RUN:     if (count == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            acc          <= '0;
            op           <= '0;
            count        <= '0;
            carry        <= 1'b0;
            illegal_pend <= 1'b0;
            result       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.Start) begin
                    op_a         <= bus.A;
                    op_b         <= bus.B;
                    op           <= bus.Alucontrol;
                    acc          <= '0;
                    count        <= '0;
                    carry        <= uses_borrow(bus.Alucontrol);
                    illegal_pend <= !is_legal_op(bus.Alucontrol);
                    if (!is_legal_op(bus.Alucontrol)) result <= '0;
                end
                RUN: begin
                    op_a  <= op_a >> SLICE;
                    op_b  <= op_b >> SLICE;
                    acc   <= acc_nxt;
                    carry <= cout;
                    count <= count + 1'b1;
                    if (count == LAST)
                        result <= (op == ALU_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : acc_nxt;
                end
                DONE:    illegal_pend <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = (state == DONE);
    assign bus.Illegal = (state == DONE) && illegal_pend;
    assign bus.Result  = result;
    assign bus.Zero    = (result == '0);

endmodule

// File: tb/tb_serial_alu.sv
// tb/tb_serial_alu.sv - scoreboard bench for serial_alu with directed handshake cases and random operations
module tb_serial_alu;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    serial_alu_if #(.WIDTH(32)) bus ();

    serial_alu #(.WIDTH(32), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.ill = 1'b0;
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: e.r = a + b;
            4'b0110: e.r = a - b;
            4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin e.r = 32'd0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got Done=1 expected no pending operation");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", bus.Result, e.r);
                    chk("zero", {31'd0, bus.Zero}, {31'd0, (e.r == 32'd0)});
                    chk("illegal", {31'd0, bus.Illegal}, {31'd0, e.ill});
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.Start      = 1'b1;
        bus.Alucontrol = op;
        bus.A          = a;
        bus.B          = b;
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.Start      = 1'b0;
        bus.A          = $urandom;
        bus.B          = $urandom;
        bus.Alucontrol = 4'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.Busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.Busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got Busy=%b expected 0 within 20 cycles", bus.Busy);
        end
    endtask

    task automatic latency(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_busy, input int exp_done);
        int busy_n  = 0;
        int done_at = -1;
        issue(op, a, b);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.Busy === 1'b1) busy_n++;
            if (bus.Done === 1'b1 && done_at < 0) done_at = c;
        end
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        chk({name, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    endtask

    initial begin
        logic [3:0]  ops [7];
        logic [31:0] edges [5];
        logic [31:0] a, b;
        ops   = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, 4'b0011, 4'b1111};
        edges = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1};

        bus.Start      = 1'b0;
        bus.Alucontrol = 4'd0;
        bus.A          = 32'd0;
        bus.B          = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_done", {31'd0, bus.Done}, 32'd0);
        chk("reset_illegal", {31'd0, bus.Illegal}, 32'd0);
        chk("reset_result", bus.Result, 32'd0);
        chk("reset_zero", {31'd0, bus.Zero}, 32'd1);
        rst = 1'b0;

        latency("add", ALU_ADD, 32'd5, 32'd7, 9, 9);
        issue(ALU_SUB, 32'd3, 32'd5);             wait_idle();
        issue(ALU_SUB, 32'h1234, 32'h1234);       wait_idle();
        issue(ALU_SLT, 32'hFFFFFFFF, 32'd1);      wait_idle();
        issue(ALU_SLT, 32'h7FFFFFFF, 32'h80000000); wait_idle();
        issue(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00); wait_idle();
        issue(ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00); wait_idle();
        latency("illegal", 4'b1111, 32'h12345678, 32'h1, 1, 1);

        // Start in cycle 4 of a running ADD must not disturb it
        issue(ALU_ADD, 32'd100, 32'd23);
        repeat (3) @(negedge clk);
        bus.Start      = 1'b1;
        bus.Alucontrol = ALU_OR;
        bus.A          = 32'hFFFFFFFF;
        bus.B          = 32'hFFFFFFFF;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_idle();

        // reset in cycle 5 aborts the operation without a Done
        issue(ALU_SUB, 32'd9, 32'd1);
        void'(exp_q.pop_back());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        chk("abort_done", {31'd0, bus.Done}, 32'd0);
        chk("abort_result", bus.Result, 32'd0);
        chk("abort_zero", {31'd0, bus.Zero}, 32'd1);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 32'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            issue(ops[$urandom_range(0, 6)], a, b);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Multi-cycle, slice-serial ALU that executes the 4-bit Alucontrol operation codes.
- It is the consumer end of the ALU-control interface.
- Operands are processed SLICE bits per cycle, LSB slice first. Start/Busy/Done handshake.
- Sits in the execute stage of the low-area multi-cycle datapath, driven by the ALU control decoder.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH mod SLICE must be 0.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- Alucontrol  in  4  operation code, captured with Start.
- A  in  WIDTH  operand A, captured with Start.
- B  in  WIDTH  operand B, captured with Start.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle completion pulse.
- Result  out  WIDTH  last completed result; held between operations.
- Zero  out  1  high when Result == 0; held with Result.
- Illegal  out  1  high with Done when the captured code is unsupported.

Behaviour:
- Single clock, synchronous active-high reset (rst), clock named clk.
- Reset forces state IDLE. Busy=0, Done=0, Illegal=0, Result=0, Zero=1. Internal shift registers, slice counter and carry are cleared.
- Reset mid-operation aborts it: no Done is produced and Result returns to 0.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed)
  - all other codes are illegal.
- States: IDLE, RUN, DONE.
- IDLE with Start=1: capture A, B, Alucontrol into registers.
  - Legal code: set count=0 and carry = 1 for SUB/SLT, 0 otherwise. Go to RUN.
  - Illegal code: go directly to DONE with Illegal pending.
- IDLE with Start=0: stay in IDLE.
- RUN, one slice per cycle (N = WIDTH/SLICE cycles):
  - Low slice of A and B goes through the slice operation (B inverted for SUB/SLT). Output slice is shifted into the accumulator from the MSB end.
  - Carry out is registered for the next slice.
  - On count==N-1: go to DONE, and load Result/Zero from the completed accumulator.
- DONE: Done=1 for exactly one cycle, then return to IDLE. Illegal=1 in this cycle only for illegal codes; in that case Result=0 and Zero=1.
- Latency example (WIDTH=32, SLICE=4): Start high in cycle 0; Busy high cycles 1-9; Done high in cycle 9. Start may be reasserted in cycle 10.
- SLT: the serial path computes A-B.
  - At the final slice, N = diff MSB and V = (A[MSB]!=B[MSB]) && (diff[MSB]!=A[MSB]).
  - Result = {WIDTH-1 zeros, N^V}.
- ADD/SUB wrap modulo 2^WIDTH. No overflow or carry output.
- Start while Busy=1 is ignored: no queuing, captured operands are unaffected.
- Operand inputs may change freely after the capture cycle.
- Result never shows partial values. It changes only at completion or reset.

Decomposition:
- Package alu_pkg holds:
  - localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111;
  - the state encoding IDLE/RUN/DONE;
  - a function is_legal_op(code).
- The ALU control decoder shares the same opcode constants from this package.
- One sub-module, alu_slice: combinational SLICE-bit unit.
  - Inputs: a, b, cin, op.
  - Outputs: y, cout, and msb signals for SLT.

Test Plan:
- ADD A=5, B=7, Start in cycle 0 -> Busy cycles 1-9, Done cycle 9, Result=12, Zero=0, Illegal=0.
- SUB A=3, B=5 -> Result=32'hFFFFFFFE, Zero=0. SUB A=B=32'h1234 -> Result=0, Zero=1.
- SLT A=32'hFFFFFFFF, B=1 -> Result=1. SLT A=32'h7FFFFFFF, B=32'h80000000 -> Result=0 (overflow case).
- AND/OR A=32'hF0F0F0F0, B=32'hFF00FF00 -> AND=32'hF000F000, OR=32'hFFF0FFF0.
- Alucontrol=4'b1111 with Start -> Busy cycle 1, Done and Illegal cycle 1, Result=0, Zero=1. Prior Result is replaced.
- Start again in cycle 4 during ADD -> ignored, first result correct. rst in cycle 5 -> next cycle IDLE, Busy=0, Result=0, no Done.
